instruction_fetch: RTL and testbench

Front-end fetch stage of the 24-bit processor. Holds the program counter and issues one read at a time to instruction memory over a req/ack handshake. Captures each returned 24-bit word into an instruction register and presents it downstream to the instruction field decoder with a valid/ready handshake. Accepts a PC redirect for branches and jumps, and squashes any in-flight or held instruction when one arrives.

---
 rtl/instruction_fetch_if.sv | 51 +++++
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the two handshakes of the fetch stage plus the redirect port.
//   - imem_*      : one-at-a-time read channel to instruction memory
//   - instruction, pc, instr_valid / instr_ready : downstream to the decoder
//   - redirect, redirect_pc : branch/jump target from the back end
//   modport master : the fetch stage
//   modport slave  : the environment (memory, decoder, branch unit)
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [0:23]       imem_rdata;

    logic [0:23]       instruction;
    logic [ADDR_W-1:0] pc;
    logic              instr_valid;
    logic              instr_ready;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instruction,
        output pc,
        output instr_valid,
        input  instr_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instruction,
        input  pc,
        input  instr_valid,
        output instr_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Front-end fetch stage of the 24-bit processor. Holds the fetch PC, issues
//   a single outstanding read to instruction memory, captures the returned
//   word and presents it to the field decoder with valid/ready. A redirect
//   squashes any in-flight or held word.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-high
//     bus  : instruction_fetch_if.master (imem channel, decoder handshake,
//            redirect)
//
//   state | meaning
//   IDLE  | after reset, one cycle before the first request
//   FETCH | request outstanding at fetch_pc
//   DRAIN | redirected mid-request; waiting for the stale ack to discard it
//   VALID | word held for the decoder until accepted or squashed
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_t            state_q,         state_d;
    logic [ADDR_W-1:0] fetch_pc_q,      fetch_pc_d;
    logic [ADDR_W-1:0] fetch_pc_next_q, fetch_pc_next_d;
    logic [0:23]       instr_q,         instr_d;
    logic [ADDR_W-1:0] pc_q,            pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RST_PC;
            fetch_pc_next_q <= RST_PC;
            instr_q         <= 24'h000000;
            pc_q            <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            fetch_pc_next_q <= fetch_pc_next_d;
            instr_q         <= instr_d;
            pc_q            <= pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        fetch_pc_next_d = fetch_pc_next_q;
        instr_d         = instr_q;
        pc_d            = pc_q;

        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end
                state_d = FETCH;
            end

            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        // Returned word belongs to the old path: drop it and
                        // issue the target immediately.
                        fetch_pc_d = bus.redirect_pc;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        state_d    = VALID;
                    end
                end else if (bus.redirect) begin
                    // imem_addr must stay stable until the ack, so park the
                    // target and let the stale request complete.
                    fetch_pc_next_d = bus.redirect_pc;
                    state_d         = DRAIN;
                end
            end

            DRAIN: begin
                if (bus.imem_ack) begin
                    fetch_pc_d = bus.redirect ? bus.redirect_pc : fetch_pc_next_q;
                    state_d    = FETCH;
                end else if (bus.redirect) begin
                    fetch_pc_next_d = bus.redirect_pc;
                end
            end

            VALID: begin
                // Redirect wins over ready: the held word is squashed.
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    state_d    = FETCH;
                end else if (bus.instr_ready) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int ADDR_W = 8;

    logic clk;
    logic rst;

    int total;
    int bad;

    // memory model controls
    int   wait_cfg;
    int   wcnt;
    logic manual;
    logic ack_man;

    instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 0 holds the test-plan word, everything else
    // is {addr, ~addr, 8'h3C}.
    function automatic logic [0:23] word_at(input logic [ADDR_W-1:0] a);
        logic [0:23] w;
        if (a == 8'h00) w = 24'h50CAAA;
        else            w = {a, ~a, 8'h3C};
        return w;
    endfunction

    assign bus.imem_rdata = word_at(bus.imem_addr);
    assign bus.imem_ack   = manual ? ack_man
                                   : (bus.imem_req && (wcnt >= wait_cfg));

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
        else                               wcnt <= wcnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", bus.imem_req); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%0h exp=00", bus.imem_addr); end
        total++; if (bus.instruction !== 24'h000000) begin bad++; $display("FAIL reset_instr got=%0h exp=000000", bus.instruction); end
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%0h exp=00", bus.pc); end
        rst = 1'b0;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%0h exp=0", bus.imem_req); end
    endtask

    // Zero-wait memory, ready high: word at 0 shows for exactly one cycle.
    task automatic test_basic();
        wait_cfg = 0;
        bus.instr_ready = 1'b1;
        cyc();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL first_addr got=%0h exp=00", bus.imem_addr); end
        cyc();
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h exp=1", bus.instr_valid); end
        total++; if (bus.instruction !== 24'h50CAAA) begin bad++; $display("FAIL basic_instr got=%0h exp=50caaa", bus.instruction); end
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL basic_pc got=%0h exp=00", bus.pc); end
        cyc();
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h01) begin bad++; $display("FAIL basic_next_addr got=%0h exp=01", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL basic_next_req got=%0h exp=1", bus.imem_req); end
        bus.instr_ready = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0h exp=1", i, bus.instr_valid); end
            total++; if (bus.instruction !== 24'h01FE3C) begin bad++; $display("FAIL bp_instr[%0d] got=%0h exp=01fe3c", i, bus.instruction); end
            total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL bp_pc[%0d] got=%0h exp=01", i, bus.pc); end
            total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req[%0d] got=%0h exp=0", i, bus.imem_req); end
            cyc();
        end
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL bp_release_req got=%0h exp=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 8'h02) begin bad++; $display("FAIL bp_release_addr got=%0h exp=02", bus.imem_addr); end
        cyc();
        total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL bp_next_pc got=%0h exp=02", bus.pc); end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'hFF;
        cyc();
        bus.redirect = 1'b0;
        total++; if (bus.imem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_addr got=%0h exp=ff", bus.imem_addr); end
        cyc();
        total++; if (bus.pc !== 8'hFF) begin bad++; $display("FAIL wrap_pc got=%0h exp=ff", bus.pc); end
        total++; if (bus.instruction !== 24'hFF003C) begin bad++; $display("FAIL wrap_instr got=%0h exp=ff003c", bus.instruction); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_next_addr got=%0h exp=00", bus.imem_addr); end
    endtask

    task automatic test_redirect_drain();
        wait_cfg = 3;
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL drain_start_addr got=%0h exp=00", bus.imem_addr); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h40;
        cyc();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL drain_hold_addr[%0d] got=%0h exp=00", i, bus.imem_addr); end
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL drain_hold_req[%0d] got=%0h exp=1", i, bus.imem_req); end
            if (i < 2) cyc();
        end
        cyc();
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL drain_squash got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h40) begin bad++; $display("FAIL drain_target got=%0h exp=40", bus.imem_addr); end
        // second drain, two redirects: latest wins
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h40;
        cyc();
        bus.redirect_pc = 8'h50;
        cyc();
        bus.redirect = 1'b0;
        total++; if (bus.imem_addr !== 8'h40) begin bad++; $display("FAIL drain2_hold got=%0h exp=40", bus.imem_addr); end
        cyc();
        cyc();
        total++; if (bus.imem_addr !== 8'h50) begin bad++; $display("FAIL drain2_target got=%0h exp=50", bus.imem_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL drain2_squash got=%0h exp=0", bus.instr_valid); end
        cyc(); cyc(); cyc(); cyc();
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL drain2_valid got=%0h exp=1", bus.instr_valid); end
        total++; if (bus.pc !== 8'h50) begin bad++; $display("FAIL drain2_pc got=%0h exp=50", bus.pc); end
        total++; if (bus.instruction !== 24'h50AF3C) begin bad++; $display("FAIL drain2_instr got=%0h exp=50af3c", bus.instruction); end
    endtask

    task automatic test_redirect_valid();
        wait_cfg = 0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h20;
        bus.instr_ready = 1'b1;
        cyc();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b0;
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rv_valid got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h20) begin bad++; $display("FAIL rv_addr got=%0h exp=20", bus.imem_addr); end
        cyc();
        total++; if (bus.pc !== 8'h20) begin bad++; $display("FAIL rv_pc got=%0h exp=20", bus.pc); end
        total++; if (bus.instruction !== 24'h20DF3C) begin bad++; $display("FAIL rv_instr got=%0h exp=20df3c", bus.instruction); end
    endtask

    task automatic test_reset_midflight();
        wait_cfg = 3;
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rm_req_before got=%0h exp=1", bus.imem_req); end
        rst = 1'b1;
        cyc();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%0h exp=0", bus.imem_req); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL rm_addr got=%0h exp=00", bus.imem_addr); end
        rst = 1'b0;
        manual = 1'b1;
        ack_man = 1'b1;
        cyc();
        ack_man = 1'b0;
        manual = 1'b0;
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL late_ack_valid got=%0h exp=0", bus.instr_valid); end
        total++; if (bus.instruction !== 24'h000000) begin bad++; $display("FAIL late_ack_instr got=%0h exp=000000", bus.instruction); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL late_ack_req got=%0h exp=1", bus.imem_req); end
        cyc(); cyc(); cyc(); cyc();
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL rm_refetch_valid got=%0h exp=1", bus.instr_valid); end
        total++; if (bus.instruction !== 24'h50CAAA) begin bad++; $display("FAIL rm_refetch_instr got=%0h exp=50caaa", bus.instruction); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        wait_cfg = 0;
        wcnt = 0;
        manual = 1'b0;
        ack_man = 1'b0;
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_redirect_drain();
        test_redirect_valid();
        test_reset_midflight();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
